dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory request interface.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the core load/store path (master)
// and the memory responder (slave).
interface dmem_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqByteEn;
  logic [2:0]  reqLoadSel;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;

  modport master (
    output reqValid, reqWrite, reqAddr, reqWdata, reqByteEn, reqLoadSel, rspReady,
    input  reqReady, rspValid, rspRdata, rspErr
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWdata, reqByteEn, reqLoadSel, rspReady,
    output reqReady, rspValid, rspRdata, rspErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder over byte-lane RAM banks with fixed latency.
// Optional DMEM_MISALIGN_CHECK_EN flags misaligned halfword/word accesses via rspErr.
module dmem_lane #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [7:0]            wbyte,
  output logic [7:0]            rbyte
);
  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wbyte;
    if (re) rbyte <= mem[idx];
  end
endmodule

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int AW2       = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [AW2-1:0]        addr;
    logic [31:0]           wdata;
    logic [NUM_LANES-1:0]  be;
    logic [2:0]            sel;
  } req_t;

  state_t                        state, state_nxt;
  logic [3:0]                    cnt, cnt_nxt;
  req_t                          req_q, req_in;
  logic                          ready, accept, enter_resp;
  logic                          cur_write;
  logic [AW2-1:0]                cur_addr;
  logic [31:0]                   cur_wdata;
  logic [NUM_LANES-1:0]          cur_be;
  logic                          err_cur, err_rsp;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][7:0]     rd_lanes;
  logic                          unused_addr;

  assign req_in = '{write: bus.reqWrite, addr: bus.reqAddr[AW2-1:0], wdata: bus.reqWdata,
                    be: bus.reqByteEn, sel: bus.reqLoadSel};
  assign unused_addr = ^bus.reqAddr[31:AW2];

  assign ready  = (state == IDLE) && !rst;
  assign accept = bus.reqValid && ready;

  // With zero wait the RAM is touched on the accept edge itself, before req_q loads.
  assign cur_write = (state == IDLE) ? req_in.write : req_q.write;
  assign cur_addr  = (state == IDLE) ? req_in.addr  : req_q.addr;
  assign cur_wdata = (state == IDLE) ? req_in.wdata : req_q.wdata;
  assign cur_be    = (state == IDLE) ? req_in.be    : req_q.be;

`ifdef DMEM_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic write, input logic [1:0] a,
                                      input logic [3:0] be, input logic [2:0] sel);
    if (write)
      return ((be == 4'b1111) && (a != 2'b00)) ||
             (((be == 4'b0011) || (be == 4'b1100)) && a[0]);
    case (sel)
      3'b001, 3'b101: return a[0];
      3'b000, 3'b100: return 1'b0;
      default:        return a != 2'b00;
    endcase
  endfunction

  assign err_cur = misaligned(cur_write, cur_addr[1:0], cur_be,
                              (state == IDLE) ? req_in.sel : req_q.sel);
  assign err_rsp = misaligned(req_q.write, req_q.addr[1:0], req_q.be, req_q.sel);
`else
  assign err_cur = 1'b0;
  assign err_rsp = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP: if (bus.rspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
    if (accept) req_q <= req_in;
  end

  // A reset landing on the RESP-entry edge must not commit the store.
  genvar n;
  generate
    for (n = 0; n < NUM_LANES; n++) begin : g_lane
      assign lane_we[n] = enter_resp && !rst && cur_write && cur_be[n] && !err_cur;
      dmem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
        .clk   (clk),
        .we    (lane_we[n]),
        .re    (enter_resp),
        .idx   (cur_addr[AW2-1:2]),
        .wbyte (cur_wdata[8*n +: 8]),
        .rbyte (rd_lanes[n])
      );
    end
  endgenerate

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] sel);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sel)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign bus.reqReady = ready;
  assign bus.rspValid = (state == RESP);
  assign bus.rspErr   = (state == RESP) && err_rsp;
  assign bus.rspRdata = ((state == RESP) && !req_q.write && !err_rsp)
                        ? extend(rd_lanes, req_q.addr[1:0], req_q.sel) : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_WIDTH=10, WAIT_CYCLES=2) with hand-computed results.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [2:0] sel);
    bus.reqWrite   = wr;
    bus.reqAddr    = a;
    bus.reqWdata   = wd;
    bus.reqByteEn  = be;
    bus.reqLoadSel = sel;
  endtask

  // Full transaction; lat counts negedges from accept until rspValid seen (-1 on timeout).
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [2:0] sel,
                      output logic [31:0] rd, output logic err, output int lat);
    int n;
    rd  = 32'hx;
    err = 1'bx;
    lat = -1;
    @(negedge clk);
    drive(wr, a, wd, be, sel);
    bus.reqValid = 1'b1;
    bus.rspReady = 1'b1;
    n = 0;
    while (!bus.reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.reqReady) begin
      bus.reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rspValid && n < 20);
    if (!bus.rspValid) return;
    lat = n;
    rd  = bus.rspRdata;
    err = bus.rspErr;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;

  initial begin
    bus.reqValid = 1'b0;
    bus.rspReady = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 4'd0, 3'd2);

    repeat (3) @(negedge clk);
    chk("rst_reqReady", {31'd0, bus.reqReady}, 32'd0);
    chk("rst_rspValid", {31'd0, bus.rspValid}, 32'd0);
    chk("rst_rspRdata", bus.rspRdata, 32'd0);
    chk("rst_rspErr",   {31'd0, bus.rspErr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_reqReady", {31'd0, bus.reqReady}, 32'd1);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, rd, err, lat);
    chk("sw_lat", lat, 3);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", {31'd0, err}, 32'd0);
    xact(1'b0, 32'h10, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("lw_lat", lat, 3);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    xact(1'b1, 32'h20, 32'h0, 4'hF, 3'd2, rd, err, lat);
    xact(1'b1, 32'h22, 32'h00800000, 4'b0100, 3'd2, rd, err, lat);
    xact(1'b0, 32'h22, 32'd0, 4'h0, 3'b000, rd, err, lat);
    chk("lb_sign", rd, 32'hFFFFFF80);
    xact(1'b0, 32'h22, 32'd0, 4'h0, 3'b100, rd, err, lat);
    chk("lbu_zero", rd, 32'h00000080);
    xact(1'b0, 32'h20, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("sb_word", rd, 32'h00800000);

    xact(1'b1, 32'h4, 32'h80017FFF, 4'hF, 3'd2, rd, err, lat);
    xact(1'b0, 32'h6, 32'd0, 4'h0, 3'b001, rd, err, lat);
    chk("lh_sign", rd, 32'hFFFF8001);
    xact(1'b0, 32'h4, 32'd0, 4'h0, 3'b101, rd, err, lat);
    chk("lhu_zero", rd, 32'h00007FFF);
    xact(1'b0, 32'h5, 32'd0, 4'h0, 3'b000, rd, err, lat);
    chk("lb_pos", rd, 32'h0000007F);
    xact(1'b0, 32'h7, 32'd0, 4'h0, 3'b100, rd, err, lat);
    chk("lbu_lane3", rd, 32'h00000080);
    xact(1'b0, 32'h4, 32'd0, 4'h0, 3'b011, rd, err, lat);
    chk("sel_unlisted", rd, 32'h80017FFF);

    xact(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 3'd2, rd, err, lat);
    chk("be0_lat", lat, 3);
    xact(1'b0, 32'h4, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("be0_nochange", rd, 32'h80017FFF);

    // 0x1010 wraps onto word index 4 (byte 0x10)
    xact(1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, 3'd2, rd, err, lat);
    xact(1'b0, 32'h10, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("wrap", rd, 32'hCAFEF00D);

`ifdef DMEM_MISALIGN_CHECK_EN
    xact(1'b0, 32'h2, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("mis_lw_err", {31'd0, err}, 32'd1);
    chk("mis_lw_rdata", rd, 32'd0);
    chk("mis_lw_lat", lat, 3);
    xact(1'b1, 32'h11, 32'h55555555, 4'hF, 3'd2, rd, err, lat);
    chk("mis_sw_err", {31'd0, err}, 32'd1);
    xact(1'b0, 32'h10, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("mis_sw_nochange", rd, 32'hCAFEF00D);
`else
    xact(1'b0, 32'h12, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("mis_lw_ignored", rd, 32'hCAFEF00D);
    chk("mis_lw_noerr", {31'd0, err}, 32'd0);
`endif

    // Backpressure: hold rspReady low while a second request waits.
    @(negedge clk);
    drive(1'b0, 32'h4, 32'd0, 4'h0, 3'b010);
    bus.reqValid = 1'b1;
    bus.rspReady = 1'b0;
    @(posedge clk);
    #1 drive(1'b0, 32'h10, 32'd0, 4'h0, 3'b010);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rspValid && lat < 20);
    chk("hold_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, bus.rspValid}, 32'd1);
      chk("hold_rdata", bus.rspRdata, 32'h80017FFF);
      chk("hold_ready", {31'd0, bus.reqReady}, 32'd0);
      @(negedge clk);
    end
    bus.rspReady = 1'b1;
    @(negedge clk);
    chk("hold_idle_ready", {31'd0, bus.reqReady}, 32'd1);
    chk("hold_idle_valid", {31'd0, bus.rspValid}, 32'd0);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rspValid && lat < 20);
    chk("second_lat", lat, 3);
    chk("second_rdata", bus.rspRdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;

    // Reset in WAIT drops the store.
    xact(1'b1, 32'h8, 32'h11111111, 4'hF, 3'd2, rd, err, lat);
    @(negedge clk);
    drive(1'b1, 32'h8, 32'h12345678, 4'hF, 3'd2);
    bus.reqValid = 1'b1;
    chk("rstw_ready", {31'd0, bus.reqReady}, 32'd1);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_valid", {31'd0, bus.rspValid}, 32'd0);
    chk("rstw_reqReady", {31'd0, bus.reqReady}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstw_no_rsp", {31'd0, bus.rspValid}, 32'd0);
    end
    xact(1'b0, 32'h8, 32'd0, 4'h0, 3'b010, rd, err, lat);
    chk("rstw_prior", rd, 32'h11111111);
    chk("rstw_lat", lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
